// File: rtl/mmp_regwr_cdc.sv
// rtl/mmp_regwr_cdc.sv - lossless register-write CDC from the i_CLK_A domain to the i_CLK_B domain
//
// Writes accepted in the i_CLK_A domain are queued in a small FIFO. A 4-phase REQ/ACK
// handshake then carries each word across to the i_CLK_B domain. The word sits in a hold
// register that does not change while REQ is high, so the data itself needs no
// synchronizer. Each accepted write produces exactly one o_WR_B strobe, and the strobes
// come out in the order the writes were accepted.
//
// Parameters:
//   AW     address width
//   DW     data width
//   DEPTH  FIFO entries (power of 2, >= 2)
//
// Ports:
//   i_CLK_A    host-domain clock
//   i_RST_n    synchronous active-low reset, sampled by both i_CLK_A and i_CLK_B
//   i_CLK_B    sound-core clock, asynchronous to i_CLK_A
//   i_WR       (A) write request, accepted when o_FULL is low
//   i_ADDR     (A) register address
//   i_DATA     (A) register data
//   o_FULL     (A) FIFO full; i_WR is ignored while this is high
//   o_IDLE     (A) FIFO empty and handshake idle (all writes delivered)
//   o_WR_B     (B) one-cycle write strobe
//   o_ADDR_B   (B) address, held until the next strobe
//   o_DATA_B   (B) data, held until the next strobe
//   o_DROPCNT  (A) saturating count of writes dropped while full
//              (present only when MMP_REGWR_CDC_DROPCNT_EN is defined)
//
// Optional feature macro: MMP_REGWR_CDC_DROPCNT_EN

module mmp_regwr_cdc #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          i_CLK_A,
    input  logic          i_RST_n,
    input  logic          i_CLK_B,
    input  logic          i_WR,
    input  logic [AW-1:0] i_ADDR,
    input  logic [DW-1:0] i_DATA,
    output logic          o_FULL,
    output logic          o_IDLE,
    output logic          o_WR_B,
    output logic [AW-1:0] o_ADDR_B,
`ifdef MMP_REGWR_CDC_DROPCNT_EN
    output logic [DW-1:0] o_DATA_B,
    output logic [7:0]    o_DROPCNT
`else
    output logic [DW-1:0] o_DATA_B
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_LO = 2'd2
    } state_t;

    // ---------------- A domain ----------------
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    logic          req_a;
    logic [EW-1:0] hold;
    logic          ack_s1;
    logic          ack_s2;
    logic          ack_b;
    logic          push;
    logic          pop;

    assign o_FULL = (count == CW'(DEPTH));
    assign o_IDLE = (state == ST_IDLE) && (count == '0);
    assign push   = i_WR && !o_FULL;
    // The head entry is released only once the far side has acknowledged it.
    assign pop    = (state == ST_REQ) && ack_s2;

    always_ff @(posedge i_CLK_A) begin
        if (push) begin
            mem[wr_ptr] <= {i_ADDR, i_DATA};
        end
    end

    always_ff @(posedge i_CLK_A) begin
        if (!i_RST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK_A) begin
        if (!i_RST_n) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= ack_b;
            ack_s2 <= ack_s1;
        end
    end

    always_ff @(posedge i_CLK_A) begin
        if (!i_RST_n) begin
            state <= ST_IDLE;
            req_a <= 1'b0;
            hold  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        hold  <= mem[rd_ptr];
                        req_a <= 1'b1;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_s2) begin
                        req_a <= 1'b0;
                        state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    // Wait for ACK to fall so the next REQ edge is a clean rise.
                    if (!ack_s2) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req_a <= 1'b0;
                end
            endcase
        end
    end

`ifdef MMP_REGWR_CDC_DROPCNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge i_CLK_A) begin
        if (!i_RST_n) begin
            drop_cnt <= 8'd0;
        end else if (i_WR && o_FULL && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign o_DROPCNT = drop_cnt;
`endif

    // ---------------- B domain ----------------
    logic req_s1;
    logic req_s2;
    logic req_s3;

    always_ff @(posedge i_CLK_B) begin
        if (!i_RST_n) begin
            req_s1   <= 1'b0;
            req_s2   <= 1'b0;
            req_s3   <= 1'b0;
            ack_b    <= 1'b0;
            o_WR_B   <= 1'b0;
            o_ADDR_B <= '0;
            o_DATA_B <= '0;
        end else begin
            req_s1 <= req_a;
            req_s2 <= req_s1;
            req_s3 <= req_s2;
            if (req_s2 && !req_s3) begin
                // REQ has been high for two B edges, so hold has long been stable.
                o_ADDR_B <= hold[EW-1:DW];
                o_DATA_B <= hold[DW-1:0];
                o_WR_B   <= 1'b1;
                ack_b    <= 1'b1;
            end else begin
                o_WR_B <= 1'b0;
                if (!req_s2) begin
                    ack_b <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmp_regwr_cdc.sv
// tb/tb_mmp_regwr_cdc.sv - self-checking bench for mmp_regwr_cdc
`timescale 1ns/1ps

module tb_mmp_regwr_cdc;

    logic       clk_a = 1'b0;
    logic       clk_b = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] data = 8'h00;
    logic       full;
    logic       idle;
    logic       wr_b;
    logic [7:0] addr_b;
    logic [7:0] data_b;
`ifdef MMP_REGWR_CDC_DROPCNT_EN
    logic [7:0] dropcnt;
`endif

    mmp_regwr_cdc #(.AW(8), .DW(8), .DEPTH(4)) dut (
        .i_CLK_A  (clk_a),
        .i_RST_n  (rst_n),
        .i_CLK_B  (clk_b),
        .i_WR     (wr),
        .i_ADDR   (addr),
        .i_DATA   (data),
        .o_FULL   (full),
        .o_IDLE   (idle),
        .o_WR_B   (wr_b),
        .o_ADDR_B (addr_b),
`ifdef MMP_REGWR_CDC_DROPCNT_EN
        .o_DATA_B (data_b),
        .o_DROPCNT(dropcnt)
`else
        .o_DATA_B (data_b)
`endif
    );

    // Half periods: 50 MHz and 21.477 MHz by default, swapped in one suite.
    realtime ha = 10.0;
    realtime hb = 23.2807;
    realtime ph = 0.0;

    initial forever #(ha) clk_a = ~clk_a;
    initial forever begin
        #(hb + ph);
        ph = 0.0;
        clk_b = ~clk_b;
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an ordered list of accepted writes, the last value delivered, and the drop count.
    logic [15:0] exp_q[$];
    logic [7:0]  mdl_addr = 8'h00;
    logic [7:0]  mdl_data = 8'h00;
    int          mdl_drops = 0;
    bit          chk_en = 1'b0;
    int          n_strobe = 0;
    bit          prev_wr = 1'b0;
    logic [7:0]  last_addr = 8'h00;
    logic [7:0]  last_data = 8'h00;
    realtime     t_strobe = 0.0;

    always @(negedge clk_b) begin
        logic [15:0] e;
        if (wr_b === 1'b1) begin
            n_strobe++;
            t_strobe  = $realtime - hb;
            last_addr = addr_b;
            last_data = data_b;
        end
        if (chk_en) begin
            if (wr_b === 1'b1) begin
                chk("strobe_not_adjacent", 32'(prev_wr), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("strobe_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    mdl_addr = e[15:8];
                    mdl_data = e[7:0];
                    chk("strobe_addr", 32'(addr_b), 32'(mdl_addr));
                    chk("strobe_data", 32'(data_b), 32'(mdl_data));
                end
            end else begin
                chk("hold_addr", 32'(addr_b), 32'(mdl_addr));
                chk("hold_data", 32'(data_b), 32'(mdl_data));
            end
        end
        prev_wr = (wr_b === 1'b1);
    end

    // Present one write for exactly one A edge; acceptance follows o_FULL before that edge.
    task automatic write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk_a);
        wr = 1'b1; addr = a; data = d;
        if (full) begin
            if (mdl_drops < 255) mdl_drops++;
        end else begin
            exp_q.push_back({a, d});
        end
    endtask

    task automatic write_retry(input logic [7:0] a, input logic [7:0] d, inout bit seen_full);
        for (int k = 0; k < 500; k++) begin
            @(negedge clk_a);
            wr = 1'b1; addr = a; data = d;
            if (full) begin
                seen_full = 1'b1;
                if (mdl_drops < 255) mdl_drops++;
            end else begin
                exp_q.push_back({a, d});
                return;
            end
        end
        chk("retry_timeout", 32'(full), 32'd0);
    endtask

    task automatic idle_a();
        @(negedge clk_a);
        wr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk_a);
            if (idle && exp_q.size() == 0) break;
        end
        chk({name, "_idle"}, 32'(idle), 32'd1);
        chk({name, "_all_delivered"}, 32'(exp_q.size()), 32'd0);
        repeat (10) @(negedge clk_b);
    endtask

    task automatic do_reset(input logic wr_during, input bit check);
        chk_en = 1'b0;
        @(negedge clk_a);
        rst_n = 1'b0; wr = wr_during; addr = 8'h99; data = 8'h77;
        repeat (6) @(posedge clk_a);
        repeat (6) @(posedge clk_b);
        if (check) begin
            @(negedge clk_a);
            chk("rst_idle", 32'(idle), 32'd1);
            chk("rst_full", 32'(full), 32'd0);
            @(negedge clk_b);
            chk("rst_wr_b", 32'(wr_b), 32'd0);
            chk("rst_addr_b", 32'(addr_b), 32'd0);
            chk("rst_data_b", 32'(data_b), 32'd0);
        end
        exp_q.delete();
        mdl_addr = 8'h00; mdl_data = 8'h00; mdl_drops = 0;
        @(negedge clk_a);
        rst_n = 1'b1; wr = 1'b0;
        repeat (4) @(negedge clk_b);
        chk_en = 1'b1;
    endtask

    task automatic run_suite();
        realtime t_req, dt;
        bit      seen_full;
        // Single write and its latency.
        n_strobe = 0;
        write(8'h12, 8'hAB);
        t_req = $realtime + 3.0 * ha;
        idle_a();
        wait_drain("t2");
        chk("t2_strobes", 32'(n_strobe), 32'd1);
        chk("t2_addr", 32'(last_addr), 32'h12);
        chk("t2_data", 32'(last_data), 32'hAB);
        dt = t_strobe - t_req;
        chk("t2_latency_in_window",
            32'((dt > 4.0 * hb - 0.01) && (dt <= 8.0 * hb + 0.01)), 32'd1);

        // Four back-to-back writes fill the FIFO.
        n_strobe = 0;
        for (int i = 0; i < 4; i++) write(8'(i), 8'(8'h10 + i));
        idle_a();
        chk("t3_full", 32'(full), 32'd1);
        wait_drain("t3");
        chk("t3_strobes", 32'(n_strobe), 32'd4);

        // Fifth write while full is dropped.
        n_strobe = 0;
        for (int i = 0; i < 4; i++) write(8'(i), 8'(8'h10 + i));
        @(negedge clk_a);
        chk("t4_full_at_5th", 32'(full), 32'd1);
        wr = 1'b1; addr = 8'h04; data = 8'h14;
        if (full) mdl_drops++; else exp_q.push_back({8'h04, 8'h14});
        idle_a();
        wait_drain("t4");
        chk("t4_strobes", 32'(n_strobe), 32'd4);
        chk("t4_drops", 32'(mdl_drops), 32'd1);
`ifdef MMP_REGWR_CDC_DROPCNT_EN
        chk("t4_dropcnt", 32'(dropcnt), 32'd1);
`endif

        // Ten writes with retry; pointers wrap, ordering is checked per strobe.
        n_strobe = 0;
        seen_full = 1'b0;
        for (int i = 0; i < 10; i++) write_retry(8'(8'h20 + i), 8'(8'hA0 + i), seen_full);
        idle_a();
        wait_drain("t5");
        chk("t5_strobes", 32'(n_strobe), 32'd10);
        chk("t5_saw_full", 32'(seen_full), 32'd1);
`ifdef MMP_REGWR_CDC_DROPCNT_EN
        @(negedge clk_a);
        chk("t5_dropcnt", 32'(dropcnt), 32'(mdl_drops));
`endif
    endtask

    initial begin
        // Reset with i_WR held: nothing may be pushed.
        n_strobe = 0;
        do_reset(1'b1, 1'b1);
        repeat (30) @(negedge clk_a);
        chk("t1_no_strobe", 32'(n_strobe), 32'd0);
        chk("t1_idle", 32'(idle), 32'd1);
        chk("t1_full", 32'(full), 32'd0);

        run_suite();

        // Reset while REQ is high: the in-flight word must not be delivered.
        n_strobe = 0;
        write(8'h77, 8'h88);
        idle_a();
        do_reset(1'b0, 1'b0);
        repeat (60) @(negedge clk_a);
        chk("t6_no_strobe", 32'(n_strobe), 32'd0);
        write(8'h55, 8'h66);
        idle_a();
        wait_drain("t6");
        chk("t6_strobes", 32'(n_strobe), 32'd1);
        chk("t6_addr", 32'(last_addr), 32'h55);
        chk("t6_data", 32'(last_data), 32'h66);

        // CLK_B faster, random phase.
        ha = 23.2807; hb = 10.0;
        ph = real'($urandom_range(0, 9000)) / 1000.0;
        do_reset(1'b0, 1'b0);
        run_suite();

        // Original ratio again with a random phase.
        ha = 10.0; hb = 23.2807;
        ph = real'($urandom_range(0, 20000)) / 1000.0;
        do_reset(1'b0, 1'b0);
        run_suite();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", nvec);
        $fatal(1, "watchdog");
    end

endmodule
